// File: rtl/traffic_cmd_deser.sv
// Three-byte command frame deserialiser for the traffic_lights command input.
// Validates header sync/type, enforces an inter-byte idle timeout, counts errors.
module traffic_cmd_deser #(
  parameter logic [4:0]  SYNC        = 5'b10101,
  parameter int unsigned TIMEOUT_CLK = 2000
) (
  input  logic        clk_i,
  input  logic        srst_n_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [2:0]  cmd_type_o,
  output logic [15:0] cmd_data_o,
  output logic        cmd_valid_o,
  output logic        frame_err_o,
  output logic [7:0]  err_cnt_o
);

  localparam int unsigned IW = (TIMEOUT_CLK > 2) ? $clog2(TIMEOUT_CLK) : 1;
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CLK - 1);

  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_DHI  = 2'd1;
  localparam logic [1:0] ST_DLO  = 2'd2;
  localparam logic [1:0] ST_EMIT = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [2:0]    type_q, type_d;
  logic [7:0]    dhi_q, dhi_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          ready_q, ready_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          frame_err_q, frame_err_d;
  logic [2:0]    cmd_type_q, cmd_type_d;
  logic [15:0]   cmd_data_q, cmd_data_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          accept;
  logic [2:0]    hdr_type;
  logic [15:0]   frame_data;

  assign accept     = byte_valid_i & ready_q;
  assign hdr_type   = byte_data_i[2:0];
  assign frame_data = {dhi_q, byte_data_i};

  always_comb begin
    state_d     = state_q;
    type_d      = type_q;
    dhi_d       = dhi_q;
    idle_d      = idle_q;
    cmd_type_d  = cmd_type_q;
    cmd_data_d  = cmd_data_q;
    cmd_valid_d = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_HDR: begin
        idle_d = '0;
        if (accept) begin
          if (byte_data_i[7:3] == SYNC && hdr_type < 3'd6) begin
            type_d  = hdr_type;
            state_d = ST_DHI;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      ST_DHI, ST_DLO: begin
        if (accept) begin
          idle_d = '0;
          if (state_q == ST_DHI) begin
            dhi_d   = byte_data_i;
            state_d = ST_DLO;
          end else begin
            // Outcome is decided on the last byte so both strobes land in the EMIT cycle.
            state_d = ST_EMIT;
            if (type_q >= 3'd3 && frame_data == 16'd0) begin
              frame_err_d = 1'b1;
            end else begin
              cmd_valid_d = 1'b1;
              cmd_type_d  = type_q;
              cmd_data_d  = (type_q < 3'd3) ? 16'd0 : frame_data;
            end
          end
        end else if (idle_q == IDLE_MAX) begin
          idle_d      = '0;
          state_d     = ST_HDR;
          frame_err_d = 1'b1;
        end else begin
          idle_d = idle_q + IW'(1);
        end
      end
      ST_EMIT: begin
        idle_d  = '0;
        state_d = ST_HDR;
      end
      default: begin
        idle_d  = '0;
        state_d = ST_HDR;
      end
    endcase

    ready_d   = (state_d != ST_EMIT);
    err_cnt_d = (frame_err_d && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q     <= ST_HDR;
      type_q      <= '0;
      dhi_q       <= '0;
      idle_q      <= '0;
      ready_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      cmd_type_q  <= '0;
      cmd_data_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      type_q      <= type_d;
      dhi_q       <= dhi_d;
      idle_q      <= idle_d;
      ready_q     <= ready_d;
      cmd_valid_q <= cmd_valid_d;
      frame_err_q <= frame_err_d;
      cmd_type_q  <= cmd_type_d;
      cmd_data_q  <= cmd_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign byte_ready_o = ready_q;
  assign cmd_valid_o  = cmd_valid_q;
  assign frame_err_o  = frame_err_q;
  assign cmd_type_o   = cmd_type_q;
  assign cmd_data_o   = cmd_data_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_traffic_cmd_deser.sv
// Randomised and directed bench for traffic_cmd_deser against a frame-level
// reference model holding the partial frame in a byte queue.
module tb_traffic_cmd_deser;

  localparam logic [4:0] SYNC = 5'b10101;
  localparam int         TO   = 2000;

  logic        clk = 1'b0;
  logic        srst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready_o;
  logic [2:0]  cmd_type_o;
  logic [15:0] cmd_data_o;
  logic        cmd_valid_o;
  logic        frame_err_o;
  logic [7:0]  err_cnt_o;

  always #5 clk = ~clk;

  traffic_cmd_deser #(.SYNC(SYNC), .TIMEOUT_CLK(TO)) dut (
    .clk_i       (clk),
    .srst_n_i    (srst_n),
    .byte_data_i (byte_data),
    .byte_valid_i(byte_valid),
    .byte_ready_o(byte_ready_o),
    .cmd_type_o  (cmd_type_o),
    .cmd_data_o  (cmd_data_o),
    .cmd_valid_o (cmd_valid_o),
    .frame_err_o (frame_err_o),
    .err_cnt_o   (err_cnt_o)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0]  mq[$];
  int          m_idle = 0;
  int          m_cnt = 0;
  bit          m_ready = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_err = 1'b0;
  bit          m_acc = 1'b0;
  logic [2:0]  m_type = '0;
  logic [15:0] m_data = '0;

  function automatic logic [29:0] obs();
    return {byte_ready_o, cmd_valid_o, frame_err_o, cmd_type_o, cmd_data_o, err_cnt_o};
  endfunction

  function automatic logic [29:0] expv();
    return {m_ready, m_valid, m_err, m_type, m_data, 8'(m_cnt)};
  endfunction

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    logic [15:0] fd;
    logic [2:0]  t;
    bit          emit;
    emit    = 1'b0;
    m_acc   = 1'b0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    if (!r) begin
      mq.delete();
      m_idle  = 0;
      m_ready = 1'b0;
      m_type  = '0;
      m_data  = '0;
      m_cnt   = 0;
      return;
    end
    m_acc = v && m_ready;
    if (m_acc) begin
      m_idle = 0;
      if (mq.size() == 0) begin
        if (d[7:3] == SYNC && d[2:0] <= 3'd5) mq.push_back(d);
        else m_err = 1'b1;
      end else if (mq.size() == 1) begin
        mq.push_back(d);
      end else begin
        emit = 1'b1;
        t  = mq[0][2:0];
        fd = {mq[1], d};
        mq.delete();
        if (t >= 3'd3 && fd == 16'd0) m_err = 1'b1;
        else begin
          m_valid = 1'b1;
          m_type  = t;
          m_data  = (t < 3'd3) ? 16'd0 : fd;
        end
      end
    end else if (mq.size() != 0) begin
      if (m_idle == TO - 1) begin
        mq.delete();
        m_idle = 0;
        m_err  = 1'b1;
      end else begin
        m_idle++;
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
    m_ready = !emit;
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic r);
    byte_valid = v;
    byte_data  = d;
    srst_n     = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask

  task automatic do_reset();
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b0);
    tick(1'b0, 8'h00, 1'b1);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 8'hAC, 1'b0);
      checks++;
      if (obs() !== 30'd0) begin
        failures++;
        $display("FAIL reset_state got=%h exp=%h", obs(), 30'd0);
      end
    end
    tick(1'b0, 8'h00, 1'b1);
    checks++;
    if (byte_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL ready_after_reset got=%b exp=1", byte_ready_o);
    end
    checks++;
    if (obs() !== expv()) begin
      failures++;
      $display("FAIL post_reset_model got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_basic();
    logic [7:0] fr[3] = '{8'hAC, 8'h00, 8'h05};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, fr[i], 1'b1);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL basic_model got=%h exp=%h", obs(), expv());
      end
    end
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o} !== {1'b1, 3'd4, 16'd5}) begin
      failures++;
      $display("FAIL basic_cmd got=%b/%0d/%0d exp=1/4/5", cmd_valid_o, cmd_type_o, cmd_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      checks++;
      if ({cmd_valid_o, cmd_type_o, cmd_data_o} !== {1'b0, 3'd4, 16'd5}) begin
        failures++;
        $display("FAIL basic_hold got=%b/%0d/%0d exp=0/4/5", cmd_valid_o, cmd_type_o, cmd_data_o);
      end
    end
  endtask

  task automatic test_zero_data();
    logic [7:0] fa[3] = '{8'hA8, 8'h12, 8'h34};
    logic [7:0] fb[3] = '{8'hAB, 8'h00, 8'h00};
    do_reset();
    for (int i = 0; i < 3; i++) tick(1'b1, fa[i], 1'b1);
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o} !== {1'b1, 3'd0, 16'd0}) begin
      failures++;
      $display("FAIL type0_forced got=%b/%0d/%h exp=1/0/0000", cmd_valid_o, cmd_type_o, cmd_data_o);
    end
    tick(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, fb[i], 1'b1);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL zero_model got=%h exp=%h", obs(), expv());
      end
    end
    checks++;
    if ({cmd_valid_o, frame_err_o, err_cnt_o, cmd_data_o} !== {1'b0, 1'b1, 8'd1, 16'd0}) begin
      failures++;
      $display("FAIL zero_data_err got=%b/%b/%0d/%h exp=0/1/1/0000",
               cmd_valid_o, frame_err_o, err_cnt_o, cmd_data_o);
    end
  endtask

  task automatic test_bad_hdr();
    logic [7:0] fr[5] = '{8'h55, 8'hAE, 8'hAD, 8'h00, 8'h0A};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, fr[i], 1'b1);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL badhdr_model got=%h exp=%h", obs(), expv());
      end
      if (i < 2) begin
        checks++;
        if ({frame_err_o, byte_ready_o, err_cnt_o} !== {1'b1, 1'b1, 8'(i + 1)}) begin
          failures++;
          $display("FAIL badhdr_err got=%b/%b/%0d exp=1/1/%0d", frame_err_o, byte_ready_o, err_cnt_o, i + 1);
        end
      end
    end
    checks++;
    if ({cmd_valid_o, cmd_type_o, cmd_data_o} !== {1'b1, 3'd5, 16'd10}) begin
      failures++;
      $display("FAIL badhdr_recover got=%b/%0d/%0d exp=1/5/10", cmd_valid_o, cmd_type_o, cmd_data_o);
    end
  endtask

  task automatic test_timeout();
    int first_err;
    do_reset();
    tick(1'b1, 8'hAB, 1'b1);
    tick(1'b1, 8'h00, 1'b1);
    first_err = -1;
    for (int i = 1; i <= TO; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (frame_err_o === 1'b1 && first_err < 0) first_err = i;
      if (i >= TO - 2) begin
        checks++;
        if (obs() !== expv()) begin
          failures++;
          $display("FAIL timeout_model t=%0d got=%h exp=%h", i, obs(), expv());
        end
      end
    end
    checks++;
    if (first_err != TO) begin
      failures++;
      $display("FAIL timeout_cycle got=%0d exp=%0d", first_err, TO);
    end
    tick(1'b1, 8'h05, 1'b1);
    checks++;
    if ({frame_err_o, cmd_valid_o, err_cnt_o} !== {1'b1, 1'b0, 8'd2}) begin
      failures++;
      $display("FAIL late_byte_hdr got=%b/%b/%0d exp=1/0/2", frame_err_o, cmd_valid_o, err_cnt_o);
    end
    tick(1'b1, 8'hAB, 1'b1);
    tick(1'b1, 8'h00, 1'b1);
    for (int i = 1; i < TO; i++) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'h07, 1'b1);
    checks++;
    if ({cmd_valid_o, frame_err_o, cmd_type_o, cmd_data_o, err_cnt_o} !==
        {1'b1, 1'b0, 3'd3, 16'd7, 8'd2}) begin
      failures++;
      $display("FAIL byte_beats_timeout got=%b/%b/%0d/%0d/%0d exp=1/0/3/7/2",
               cmd_valid_o, frame_err_o, cmd_type_o, cmd_data_o, err_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] stream[$];
    logic [15:0] d;
    logic [2:0]  t;
    int pulses[$];
    do_reset();
    for (int f = 0; f < 4; f++) begin
      t = 3'($urandom_range(0, 5));
      d = 16'($urandom_range(1, 65535));
      stream.push_back({SYNC, t});
      stream.push_back(d[15:8]);
      stream.push_back(d[7:0]);
    end
    for (int i = 1; i <= 16; i++) begin
      if (stream.size() != 0) tick(1'b1, stream[0], 1'b1);
      else tick(1'b0, 8'h00, 1'b1);
      if (m_acc) void'(stream.pop_front());
      if (cmd_valid_o === 1'b1) pulses.push_back(i);
      checks++;
      if (obs() !== expv() || byte_ready_o !== !cmd_valid_o) begin
        failures++;
        $display("FAIL b2b_cycle t=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if (pulses.size() != 4 || pulses[0] != 3 || pulses[1] != 7 || pulses[2] != 11 || pulses[3] != 15) begin
      failures++;
      $display("FAIL b2b_rate got=%0d pulses first=%0d exp=4 pulses at 3,7,11,15",
               pulses.size(), (pulses.size() != 0) ? pulses[0] : -1);
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'hAD, 1'b1);
    tick(1'b1, 8'h00, 1'b1);
    tick(1'b1, 8'h11, 1'b0);
    checks++;
    if (obs() !== 30'd0) begin
      failures++;
      $display("FAIL midframe_reset got=%h exp=%h", obs(), 30'd0);
    end
    tick(1'b0, 8'h00, 1'b1);
    tick(1'b0, 8'h00, 1'b1);
    checks++;
    if ({cmd_valid_o, frame_err_o, err_cnt_o, cmd_type_o, cmd_data_o} !== '0 || obs() !== expv()) begin
      failures++;
      $display("FAIL midframe_after got=%h exp=%h", obs(), expv());
    end
  endtask

  task automatic test_saturate();
    logic [7:0] b;
    do_reset();
    for (int i = 0; i < 257; i++) begin
      b = 8'($urandom);
      if (b[7:3] == SYNC) b[7] = ~b[7];
      tick(1'b1, b, 1'b1);
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL sat_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
    checks++;
    if (err_cnt_o !== 8'd255) begin
      failures++;
      $display("FAIL err_cnt_saturate got=%0d exp=255", err_cnt_o);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       v;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      b = 8'($urandom);
      if ($urandom_range(0, 9) < 4) b[7:3] = SYNC;
      tick(v, b, ($urandom_range(0, 299) != 0));
      checks++;
      if (obs() !== expv()) begin
        failures++;
        $display("FAIL random_model i=%0d got=%h exp=%h", i, obs(), expv());
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_data();
    test_bad_hdr();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_cmd_deser.md
TRAFFIC_CMD_DESER -- requirements
Module: traffic_cmd_deser

Interface
REQ-001 The block SHALL have parameter SYNC, default 5'b10101, the header sync pattern in bits [7:3] of the header byte.
REQ-002 The block SHALL have parameter TIMEOUT_CLK, default 2000, the maximum idle clocks allowed between bytes of one frame (1 s at 2 kHz).
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port srst_n_i, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port byte_data_i, input, 8 bits: incoming frame byte.
REQ-006 The block SHALL have port byte_valid_i, input, 1 bit: byte_data_i is valid.
REQ-007 The block SHALL have port byte_ready_o, output, 1 bit: block accepts a byte this cycle.
REQ-008 The block SHALL have port cmd_type_o, output, 3 bits: decoded command type for the traffic_lights command input.
REQ-009 The block SHALL have port cmd_data_o, output, 16 bits: decoded command data, in ms.
REQ-010 The block SHALL have port cmd_valid_o, output, 1 bit: single-cycle command strobe.
REQ-011 The block SHALL have port frame_err_o, output, 1 bit: single-cycle error strobe.
REQ-012 The block SHALL have port err_cnt_o, output, 8 bits: saturating count of errors.

Function
REQ-013 A byte SHALL be accepted only in a cycle where byte_valid_i and byte_ready_o are both 1.
REQ-014 A frame SHALL be 3 bytes: header {SYNC, type[2:0]}, data[15:8], data[7:0].
REQ-015 The FSM SHALL have states HDR, DHI, DLO and EMIT; byte_ready_o SHALL be 1 in HDR, DHI and DLO, and 0 in EMIT.
REQ-016 In HDR, an accepted header whose bits [7:3] equal SYNC SHALL latch type and go to DHI; otherwise the byte is dropped, frame_err_o pulses, and the FSM stays in HDR.
REQ-017 A header whose type is 6 or 7 SHALL be discarded with a frame_err_o pulse and the FSM staying in HDR.
REQ-018 In DHI, an accepted byte SHALL be latched as data[15:8] and the FSM goes to DLO.
REQ-019 In DLO, an accepted byte SHALL be latched as data[7:0] and the FSM goes to EMIT.
REQ-020 EMIT SHALL last exactly 1 cycle, with cmd_valid_o=1, cmd_type_o and cmd_data_o valid, then return to HDR.
REQ-021 Latency: with the DLO byte accepted at cycle N, cmd_valid_o SHALL be 1 at cycle N+1.
REQ-022 cmd_type_o and cmd_data_o SHALL hold their last emitted value when cmd_valid_o=0.
REQ-023 For types 0, 1 and 2, cmd_data_o SHALL be forced to 0 regardless of the data bytes.
REQ-024 For types 3, 4 and 5, data==0 SHALL suppress cmd_valid_o in EMIT, pulse frame_err_o instead, and leave outputs unchanged.
REQ-025 An idle counter SHALL clear on every accepted byte and on entry to DHI, and count clocks while in DHI or DLO without an accepted byte.
REQ-026 When the idle counter reaches TIMEOUT_CLK-1 with no byte that cycle, the FSM SHALL abort to HDR, discard the partial frame, and pulse frame_err_o.
REQ-027 If a byte is accepted in the same cycle the timeout would fire, the byte SHALL win and no timeout occurs.
REQ-028 frame_err_o SHALL be registered and asserted for exactly 1 cycle per error event.
REQ-029 err_cnt_o SHALL increment by 1 per frame_err_o pulse and saturate at 255.
REQ-030 Back-to-back frames SHALL be sustained at 1 command per 4 cycles, since EMIT stalls input for 1 cycle.

Reset
REQ-031 With srst_n_i=0 at a rising edge, the block SHALL enter HDR and set byte_ready_o=0, cmd_valid_o=0, frame_err_o=0, cmd_type_o=0, cmd_data_o=0, err_cnt_o=0, and idle counter=0.
REQ-032 Reset asserted mid-frame SHALL discard the partial frame with no cmd_valid_o and no frame_err_o.
REQ-033 byte_ready_o SHALL be 1 from the first cycle after reset deasserts.

Verification
REQ-034 Bytes 0xAC, 0x00, 0x05 back-to-back -> cmd_valid_o=1 one cycle after the 3rd byte, with cmd_type_o=4, cmd_data_o=5; outputs hold thereafter.
REQ-035 Bytes 0xA8, 0x12, 0x34 (type 0) -> cmd_type_o=0, cmd_data_o=0; then 0xAB, 0x00, 0x00 (type 3, zero data) -> no cmd_valid_o, frame_err_o pulse, err_cnt_o=1.
REQ-036 Bytes 0x55 (bad sync), then 0xAE (type 6) -> two frame_err_o pulses with FSM staying in HDR; a following valid frame 0xAD, 0x00, 0x0A decodes as type 5, data 10.
REQ-037 Header 0xAB, 0x00, then byte_valid_i=0 for 2000 cycles -> frame_err_o at idle count 1999; a late 3rd byte is treated as a header; a byte arriving exactly at cycle 1999 completes the frame instead.
REQ-038 With byte_valid_i held 1 over 4 frames, cmd_valid_o pulses every 4 cycles and byte_ready_o is low only in EMIT cycles.
REQ-039 srst_n_i=0 after the 2nd byte of a frame -> no cmd_valid_o and all outputs at reset values; 256 bad headers -> err_cnt_o saturates at 255.
